// File: rtl/mul_unit_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter and the reservation stations.
// Op codes, FSM state type and the sign/half decode helpers.
package mul_unit_arbiter_pkg;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } mul_arb_state_t;

    // op[2] is ignored by every decode below
    function automatic logic op_a_signed(input logic [2:0] op);
        return op[1] ? !op[0] : 1'b1;
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return !op[1];
    endfunction

    // 1 selects the low product half, 0 the high half
    function automatic logic op_sel_lo(input logic [2:0] op);
        return (op[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mul_unit_arbiter_rr_pick2.sv
// Two-requester round-robin picker: valids plus last-granted pointer
// give a one-hot grant. last=1 means port 1 won last, so port 0 wins ties.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // pick the port that was not granted last when both request
    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last))
            grant = 2'b01;
        else if (valid[1])
            grant = 2'b10;
    end

endmodule

// File: rtl/mul_unit_arbiter.sv
// Shares one mul32 between two requesters, tracks the in-flight op and
// holds its result for writeback. Macro: MUL_ARB_ROUND_ROBIN_EN.
module mul_unit_arbiter
    import mul_unit_arbiter_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req0_vregid,
    input  logic [TAG_W-1:0] req1_vregid,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    output logic             mul_in_en,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_b,
    output logic             mul_a_signed,
    output logic             mul_b_signed,
    input  logic             mul_idle,
    input  logic             mul_out_en,
    input  logic [XLEN-1:0]  mul_sum_hi,
    input  logic [XLEN-1:0]  mul_sum_lo,
    output logic             wb_en,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_vregid,
    output logic [XLEN-1:0]  wb_val,
    output logic             wb_src
);

    mul_arb_state_t   state;
    logic             drop;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             src_q;
    logic             can_grant;
    logic             last;
    logic [1:0]       gnt;
    logic             sel1;
    logic [2:0]       sel_op;

    assign can_grant = (state == IDLE) && mul_idle && !flush && !drop
                     && (req0_valid || req1_valid);

`ifdef MUL_ARB_ROUND_ROBIN_EN
    logic last_q;

    // remember which port won the most recent grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= 1'b1;
        else if (can_grant)
            last_q <= gnt[1];
    end

    assign last = last_q;
`else
    // pinned pointer: port 0 always wins a tie
    assign last = 1'b1;
`endif

    rr_pick2 u_pick (
        .valid ({req1_valid, req0_valid}),
        .last  (last),
        .grant (gnt)
    );

    assign req0_ready = can_grant && gnt[0];
    assign req1_ready = can_grant && gnt[1];
    assign sel1       = gnt[1];
    assign sel_op     = sel1 ? req1_op : req0_op;

    // issue/track/writeback FSM with registered multiplier and wb outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            drop         <= 1'b0;
            op_q         <= 3'b000;
            tag_q        <= '0;
            src_q        <= 1'b0;
            mul_in_en    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_a_signed <= 1'b1;
            mul_b_signed <= 1'b1;
            wb_en        <= 1'b0;
            wb_vregid    <= '0;
            wb_val       <= '0;
            wb_src       <= 1'b0;
        end else begin
            mul_in_en <= 1'b0;
            if (drop && mul_out_en)
                drop <= 1'b0;
            if (flush) begin
                state <= IDLE;
                wb_en <= 1'b0;
                // an op already handed to mul32 will still return a result
                if (state == ISSUE || (state == BUSY && !mul_out_en))
                    drop <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (can_grant) begin
                            state        <= ISSUE;
                            mul_in_en    <= 1'b1;
                            op_q         <= sel_op;
                            tag_q        <= sel1 ? req1_vregid : req0_vregid;
                            src_q        <= sel1;
                            mul_a        <= sel1 ? req1_a : req0_a;
                            mul_b        <= sel1 ? req1_b : req0_b;
                            mul_a_signed <= op_a_signed(sel_op);
                            mul_b_signed <= op_b_signed(sel_op);
                        end
                    end
                    ISSUE: state <= BUSY;
                    BUSY: begin
                        if (mul_out_en && !drop) begin
                            state     <= WB;
                            wb_en     <= 1'b1;
                            wb_vregid <= tag_q;
                            wb_src    <= src_q;
                            wb_val    <= op_sel_lo(op_q) ? mul_sum_lo
                                                         : mul_sum_hi;
                        end
                    end
                    WB: begin
                        if (wb_ready) begin
                            state <= IDLE;
                            wb_en <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_unit_arbiter.sv
// Directed bench for mul_unit_arbiter, behavioural mul32 (latency 4).
// Build with MUL_ARB_ROUND_ROBIN_EN to expect alternating grants.
module tb_mul_unit_arbiter;

  localparam int LAT = 4;
  localparam logic [2:0] MUL_OP_MUL_C = 3'b000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [4:0]  req0_vregid, req1_vregid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        mul_in_en;
  logic [31:0] mul_a, mul_b;
  logic        mul_a_signed, mul_b_signed;
  logic        mul_idle;
  logic        mul_out_en = 1'b0;
  logic [31:0] mul_sum_hi = '0, mul_sum_lo = '0;
  logic        wb_en;
  logic        wb_ready;
  logic [4:0]  wb_vregid;
  logic [31:0] wb_val;
  logic        wb_src;

  int checks = 0;
  int errors = 0;

  mul_unit_arbiter #(.TAG_W(5), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_op      (req0_op),
    .req1_op      (req1_op),
    .req0_vregid  (req0_vregid),
    .req1_vregid  (req1_vregid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .mul_in_en    (mul_in_en),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_a_signed (mul_a_signed),
    .mul_b_signed (mul_b_signed),
    .mul_idle     (mul_idle),
    .mul_out_en   (mul_out_en),
    .mul_sum_hi   (mul_sum_hi),
    .mul_sum_lo   (mul_sum_lo),
    .wb_en        (wb_en),
    .wb_ready     (wb_ready),
    .wb_vregid    (wb_vregid),
    .wb_val       (wb_val),
    .wb_src       (wb_src)
  );

  always #5 clk = ~clk;

  logic        mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic [63:0] mdl_prod = '0;
  logic [63:0] ext_a, ext_b;

  assign mul_idle = !mdl_busy;
  assign ext_a = mul_a_signed ? {{32{mul_a[31]}}, mul_a}
                              : {32'b0, mul_a};
  assign ext_b = mul_b_signed ? {{32{mul_b[31]}}, mul_b}
                              : {32'b0, mul_b};

  always @(posedge clk) begin
    mul_out_en <= 1'b0;
    if (mdl_busy) begin
      if (mdl_cnt == 1) begin
        mul_out_en <= 1'b1;
        mul_sum_hi <= mdl_prod[63:32];
        mul_sum_lo <= mdl_prod[31:0];
        mdl_busy   <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end else if (mul_in_en) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= LAT - 1;
      mdl_prod <= ext_a * ext_b;
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wb(input string tag);
    int n;
    n = 0;
    while (!wb_en && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_wb_timeout"}, wb_en, 1'b1);
  endtask

  task automatic do_op(input logic src, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp,
                       input logic exp_as, input logic exp_bs,
                       input string name);
    int n;
    if (src) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a;
      req1_b = b; req1_vregid = tag;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a;
      req0_b = b; req0_vregid = tag;
    end
    #1;
    chk({name, "_grant"}, {req1_ready, req0_ready},
        src ? 2'b10 : 2'b01);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({name, "_in_en"}, mul_in_en, 1'b1);
    chk({name, "_signs"}, {mul_a_signed, mul_b_signed},
        {exp_as, exp_bs});
    n = 0;
    while (!wb_en && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, n, LAT + 1);
    chk({name, "_val"}, wb_val, exp);
    chk({name, "_tag"}, wb_vregid, tag);
    chk({name, "_src"}, wb_src, src);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk({name, "_wb_clear"}, wb_en, 1'b0);
  endtask

  logic exp_rr[4];

  initial begin
    int n;
    logic bad;
    logic seen;
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'b0; req1_op = 3'b0;
    req0_vregid = '0; req1_vregid = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    chk("rst_ctl", {mul_in_en, wb_en, req0_ready, req1_ready},
        4'b0000);
    chk("rst_sign", {mul_a_signed, mul_b_signed, wb_src}, 3'b110);
    chk("rst_data", {mul_a, mul_b, wb_val, wb_vregid}, 101'b0);

    do_op(1'b0, MUL_OP_MUL_C, 32'd7, 32'hFFFFFFFD, 5'd5,
          32'hFFFFFFEB, 1'b1, 1'b1, "mul");
    do_op(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12,
          32'hFFFFFFFE, 1'b0, 1'b0, "mulhu");
    do_op(1'b0, 3'b110, 32'hFFFFFFFF, 32'd2, 5'd30,
          32'hFFFFFFFF, 1'b1, 1'b0, "mulhsu");
    do_op(1'b1, 3'b001, 32'hFFFF0000, 32'h00010000, 5'd1,
          32'hFFFFFFFF, 1'b1, 1'b1, "mulh");

    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd3;
    req0_b = 32'd5; req0_vregid = 5'd9;
    #1;
    tick();
    req0_valid = 1'b0;
    wait_wb("bp");
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!wb_en || wb_val !== 32'd15 || wb_vregid !== 5'd9
          || req0_ready || req1_ready)
        bad = 1'b1;
      tick();
    end
    chk("bp_hold", bad, 1'b0);
    chk("bp_val", wb_val, 32'd15);
    wb_ready = 1'b1;
    #1;
    chk("bp_no_wbready_path", {req1_ready, req0_ready}, 2'b00);
    tick();
    wb_ready = 1'b0;
    chk("bp_wb_clear", wb_en, 1'b0);
    chk("bp_regrant", req0_ready ^ req1_ready, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd2;
    req0_b = 32'd2; req0_vregid = 5'd3;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    flush = 1'b1;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'h00010000;
    req1_b = 32'h00010000; req1_vregid = 5'd17;
    #1;
    chk("fl_ready_low", {req1_ready, req0_ready}, 2'b00);
    tick();
    flush = 1'b0;
    #1;
    bad = 1'b0;
    n = 0;
    while (!mul_out_en && n < 20) begin
      if (req1_ready || wb_en) bad = 1'b1;
      tick();
      n++;
    end
    chk("fl_drop_seen", mul_out_en, 1'b1);
    chk("fl_blocked", bad, 1'b0);
    chk("fl_drop_cycle", {req1_ready, wb_en}, 2'b00);
    tick();
    chk("fl_regrant", req1_ready, 1'b1);
    chk("fl_no_wb", wb_en, 1'b0);
    tick();
    req1_valid = 1'b0;
    wait_wb("fl");
    chk("fl_val", wb_val, 32'd1);
    chk("fl_tag", {wb_src, wb_vregid}, {1'b1, 5'd17});
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd7;
    req0_b = 32'd9; req0_vregid = 5'd21;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rb_ctl", {mul_in_en, wb_en, req0_ready, req1_ready},
        4'b0000);
    chk("rb_sign", {mul_a_signed, mul_b_signed, wb_src}, 3'b110);
    chk("rb_data", {mul_a, mul_b, wb_val, wb_vregid}, 101'b0);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mul_out_en) seen = 1'b1;
      if (wb_en) bad = 1'b1;
      tick();
    end
    chk("rb_late_out_seen", seen, 1'b1);
    chk("rb_late_out_ignored", bad, 1'b0);

`ifdef MUL_ARB_ROUND_ROBIN_EN
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_rr = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1;
    req0_b = 32'd1; req0_vregid = 5'd2;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'd1;
    req1_b = 32'd1; req1_vregid = 5'd4;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("arb_onehot%0d", k),
          {req1_ready, req0_ready} == 2'b01
          || {req1_ready, req0_ready} == 2'b10, 1'b1);
      chk($sformatf("arb_port%0d", k), req1_ready, exp_rr[k]);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    wb_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_unit_arbiter.md
# mul_unit_arbiter

Shares the single `mul32` multiplier between two reservation-station requesters (port 0: integer MUL station, port 1: secondary issue port). It grants one ready operation at a time and drives the multiplier's operand and sign controls. It tracks the in-flight tag, discards results cancelled by a pipeline flush, and holds the finished result on a back-pressured writeback port toward the CDB arbiter.

## Interface
Parameters:
- `TAG_W`, 5: width of destination virtual-register id.
- `XLEN`, 32: operand/result width; must match `mul32`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: cancel all pending/in-flight work.
- `req0_valid`, `req1_valid` in 1: requester has a ready operation.
- `req0_ready`, `req1_ready` out 1: grant; operation consumed this cycle.
- `req0_op`, `req1_op` in 3: op code.
- `req0_vregid`, `req1_vregid` in TAG_W: destination tag.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in XLEN: operands.
- `mul_in_en` out 1: start pulse to `mul32`.
- `mul_a`, `mul_b` out XLEN: multiplier operands.
- `mul_a_signed`, `mul_b_signed` out 1: sign controls.
- `mul_idle` in 1: multiplier can accept.
- `mul_out_en` in 1: multiplier result valid (one-cycle pulse).
- `mul_sum_hi`, `mul_sum_lo` in XLEN: product halves.
- `wb_en` out 1: result valid.
- `wb_ready` in 1: CDB accepts result.
- `wb_vregid` out TAG_W: result tag.
- `wb_val` out XLEN: result value.
- `wb_src` out 1: requester that issued the result.

## Operation
- Op encoding: `000` MUL (both signed, low half); `001` MULH (both signed, high); `010` MULHSU (a signed, b unsigned, high); `011` MULHU (both unsigned, high). `op[2]` is ignored.
- `a_signed = op[1] ? !op[0] : 1`; `b_signed = !op[1]`; `wb_val = (op[1:0]==00) ? sum_lo : sum_hi`.
- FSM states:
  - IDLE → ISSUE when a grant occurs.
  - ISSUE → BUSY, always, after one cycle.
  - BUSY → WB on `mul_out_en` when `drop`=0.
  - WB → IDLE on `wb_ready`.
- Grant condition: state IDLE, `mul_idle`=1, `flush`=0, `drop`=0, and at least one `reqN_valid`.
  - Exactly one `reqN_ready` is asserted.
  - Operands, op, tag and source are latched at the grant.
- Arbitration: round-robin when configured (see Configuration). The last-granted pointer toggles only on a grant. When both request, the port not granted last wins.
- Flush, in any state: FSM goes to IDLE, `wb_en` clears, and `req*_ready`=0 that cycle.
  - If flush occurs in ISSUE or BUSY, set `drop`; the next `mul_out_en` is consumed silently and clears `drop`.
  - No grant while `drop`=1.
  - A flush in ISSUE still emits `mul_in_en` that cycle, so `drop` is needed.
- `mul_out_en` in any state other than BUSY, with `drop`=0, is a protocol error and is ignored.

## Timing
- Reset values: state IDLE, `drop`=0, RR pointer=1 (port 0 wins first tie), `mul_in_en`=0, `wb_en`=0, `req*_ready`=0. `mul_a`, `mul_b`, `wb_val` and `wb_vregid` reset to 0; `mul_*_signed` reset to 1; `wb_src`=0.
- `req*_ready` is combinational from state, valids, `mul_idle`, `flush`, `drop` and pointer. It has no path from `wb_ready`.
- `mul_in_en` is a registered one-cycle pulse in ISSUE. Operands are stable from ISSUE until `mul_out_en`.
- Latency: grant at cycle T, `mul_in_en` at T+1, `mul_out_en` at T+1+L, `wb_en` at T+2+L. L is the `mul32` latency.
- `wb_en`/`wb_vregid`/`wb_val` are registered and held constant until the cycle `wb_ready`=1. `wb_en` deasserts the cycle after acceptance; the earliest next grant is that same cycle (state IDLE).
- At most one operation is in flight; throughput is one result per L+3 cycles.

## Configuration
- `MUL_ARB_ROUND_ROBIN_EN` defined: round-robin as above.
- Undefined: fixed priority, port 0 always wins; the pointer register is not built.

## Structure
- Shared package holds:
  - op-code localparams `MUL_OP_MUL/MULH/MULHSU/MULHU`;
  - FSM state enum `mul_arb_state_t` (IDLE/ISSUE/BUSY/WB);
  - sign-decode and half-select functions, reused by the reservation stations.
- One sub-module: `rr_pick2`, a two-requester round-robin picker (valids, pointer → one-hot grant).

## Test plan
- Reset mid-BUSY (assert `rst` with `mul_out_en` pending) → all outputs at reset values immediately; the later `mul_out_en` is ignored (`wb_en` stays 0).
- Single MUL, req0 a=7, b=-3, vregid=5, L=4 → `mul_in_en` at T+1; `wb_en` at T+6 with val 0xFFFFFFEB, vregid 5, src 0.
- MULHU a=b=0xFFFFFFFF → `wb_val` 0xFFFFFFFE. MULHSU a=-1, b=2 → `wb_val` 0xFFFFFFFF, `a_signed`=1, `b_signed`=0.
- Both valid continuously, round-robin build → grants alternate 0,1,0,1. Without the macro → always 0.
- `wb_ready`=0 for 5 cycles after `wb_en` → value and tag held, no new grant, `req*_ready`=0 throughout.
- Flush in BUSY, then req1 valid → no grant until the dropped `mul_out_en` arrives, no `wb_en` for the flushed op; req1 is granted the cycle after the dropped `mul_out_en`.
